operand_fetch: RTL and testbench

Issue stage between decode and execute. Accepts one decoded instruction at a time and drives the register-file read addresses. Holds the instruction until both source operands are marked valid by the register file, capturing each operand independently as soon as it becomes available. Presents the assembled operand packet to execute over a valid/ready handshake.

---
 rtl/operand_fetch_if.sv | 62 ++++++
 rtl/operand_fetch.sv | 136 +++++++++++++
 tb/tb_operand_fetch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// ============================================================================
// Module      : operand_fetch_if
// Description : Bundle of the decode, register-file, writeback-snoop and
//               execute signals around the operand-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if #(
    parameter int STALL_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_op;
    logic [4:0]         in_rs1;
    logic [4:0]         in_rs2;
    logic [4:0]         in_rd;
    logic [31:0]        in_imm;
    logic               in_use_imm;

    logic [4:0]         rf_a1;
    logic [4:0]         rf_a2;
    logic [31:0]        rf_d1;
    logic [31:0]        rf_d2;
    logic               rf_v1;
    logic               rf_v2;

    logic               wb_en;
    logic [4:0]         wb_a;
    logic [31:0]        wb_data;

    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_op;
    logic [4:0]         out_rd;
    logic [31:0]        out_a;
    logic [31:0]        out_b;
    logic [STALL_W-1:0] stall_count;

    // master: the operand-fetch stage itself; slave: its surroundings
    modport master (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
        output in_ready,
        output rf_a1, rf_a2,
        input  rf_d1, rf_d2, rf_v1, rf_v2,
        input  wb_en, wb_a, wb_data,
        output out_valid, out_op, out_rd, out_a, out_b, stall_count,
        input  out_ready
    );

    modport slave (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
        input  in_ready,
        input  rf_a1, rf_a2,
        output rf_d1, rf_d2, rf_v1, rf_v2,
        output wb_en, wb_a, wb_data,
        input  out_valid, out_op, out_rd, out_a, out_b, stall_count,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Issue stage holding one instruction until both operands are
//               captured, then offering the packet to execute. Optional
//               writeback bypass enabled by macro OPFETCH_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch #(
    parameter int STALL_W = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    operand_fetch_if.master bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_FULL = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [4:0]         rs1_q, rs1_d;
    logic [4:0]         rs2_q, rs2_d;
    logic [4:0]         rd_q, rd_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               ok_a_q, ok_a_d;
    logic               ok_b_q, ok_b_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic               w_byp_a;
    logic               w_byp_b;
    logic               w_load;

`ifdef OPFETCH_BYPASS_EN
    assign w_byp_a = bus.wb_en && (bus.wb_a == rs1_q) && (rs1_q != 5'd0);
    assign w_byp_b = bus.wb_en && (bus.wb_a == rs2_q) && (rs2_q != 5'd0);
`else
    logic w_unused_wb;
    assign w_unused_wb = ^{bus.wb_en, bus.wb_a, bus.wb_data};
    assign w_byp_a     = 1'b0;
    assign w_byp_b     = 1'b0;
`endif

    // A new instruction enters from IDLE, or from FULL on the same edge the packet leaves
    assign w_load = bus.in_valid &&
                    ((state_q == c_IDLE) || ((state_q == c_FULL) && bus.out_ready));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        ok_a_d  = ok_a_q;
        ok_b_d  = ok_b_q;
        stall_d = stall_q;

        case (state_q)
            c_IDLE: begin
                if (w_load) state_d = c_WAIT;
            end
            c_WAIT: begin
                if (!ok_a_q && (w_byp_a || bus.rf_v1)) begin
                    a_d    = w_byp_a ? bus.wb_data : bus.rf_d1;
                    ok_a_d = 1'b1;
                end
                if (!ok_b_q && (w_byp_b || bus.rf_v2)) begin
                    b_d    = w_byp_b ? bus.wb_data : bus.rf_d2;
                    ok_b_d = 1'b1;
                end
                if (ok_a_d && ok_b_d) begin
                    state_d = c_FULL;
                end else if (stall_q != {STALL_W{1'b1}}) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            c_FULL: begin
                if (bus.out_ready) state_d = bus.in_valid ? c_WAIT : c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase

        if (w_load) begin
            op_d   = bus.in_op;
            rs1_d  = bus.in_rs1;
            rs2_d  = bus.in_rs2;
            rd_d   = bus.in_rd;
            ok_a_d = 1'b0;
            ok_b_d = bus.in_use_imm;
            if (bus.in_use_imm) b_d = bus.in_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            op_q    <= 4'd0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            ok_a_q  <= 1'b0;
            ok_b_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ok_a_q  <= ok_a_d;
            ok_b_q  <= ok_b_d;
            stall_q <= stall_d;
        end
    end

    assign bus.in_ready    = (state_q == c_IDLE) || ((state_q == c_FULL) && bus.out_ready);
    assign bus.out_valid   = (state_q == c_FULL);
    assign bus.rf_a1       = (state_q == c_WAIT) ? rs1_q : 5'd0;
    assign bus.rf_a2       = (state_q == c_WAIT) ? rs2_q : 5'd0;
    assign bus.out_op      = op_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_a       = a_q;
    assign bus.out_b       = b_q;
    assign bus.stall_count = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch (directed + random),
//               aware of macro OPFETCH_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
    localparam int SW  = 4;
    localparam int SAT = (1 << SW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_if #(.STALL_W(SW)) bus ();
    operand_fetch #(.STALL_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Register-file model: value and ready flag per register
    logic [31:0] regval [32];
    logic        regv   [32];
    assign bus.rf_d1 = regval[bus.rf_a1];
    assign bus.rf_d2 = regval[bus.rf_a2];
    assign bus.rf_v1 = regv[bus.rf_a1];
    assign bus.rf_v2 = regv[bus.rf_a2];

    int checks   = 0;
    int failures = 0;

    // Reference: one instruction slot with per-operand "have" flags
    bit          m_occ, m_ha, m_hb;
    logic [3:0]  m_op;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_a, m_b;
    int          m_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit byp(input logic [4:0] r);
`ifdef OPFETCH_BYPASS_EN
        return bus.wb_en && (bus.wb_a == r) && (r != 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_occ = 0; m_ha = 0; m_hb = 0; m_stall = 0;
    endtask

    task automatic model_update();
        bit full;
        bit ld;
        full = m_occ && m_ha && m_hb;
        ld   = 0;
        if (!m_occ) begin
            ld = bus.in_valid;
        end else if (!full) begin
            if (!m_ha) begin
                if (byp(m_rs1))          begin m_a = bus.wb_data;    m_ha = 1; end
                else if (regv[m_rs1])    begin m_a = regval[m_rs1];  m_ha = 1; end
            end
            if (!m_hb) begin
                if (byp(m_rs2))          begin m_b = bus.wb_data;    m_hb = 1; end
                else if (regv[m_rs2])    begin m_b = regval[m_rs2];  m_hb = 1; end
            end
            if (!(m_ha && m_hb) && m_stall < SAT) m_stall++;
        end else if (bus.out_ready) begin
            if (bus.in_valid) ld = 1;
            else              m_occ = 0;
        end
        if (ld) begin
            m_occ = 1; m_ha = 0; m_hb = bus.in_use_imm;
            m_op = bus.in_op; m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2; m_rd = bus.in_rd;
            if (bus.in_use_imm) m_b = bus.in_imm;
        end
    endtask

    // Per-cycle comparison against the reference, 1 time unit after each edge
    always @(posedge clk) begin
        bit full;
        #1;
        if (rst_n) begin
            full = m_occ && m_ha && m_hb;
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, full});
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_occ || (full && bus.out_ready))});
            chk("rf_a1", {27'd0, bus.rf_a1}, (m_occ && !full) ? {27'd0, m_rs1} : 32'd0);
            chk("rf_a2", {27'd0, bus.rf_a2}, (m_occ && !full) ? {27'd0, m_rs2} : 32'd0);
            chk("stall_count", {28'd0, bus.stall_count}, m_stall);
            if (full) begin
                chk("out_op", {28'd0, bus.out_op}, {28'd0, m_op});
                chk("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
                chk("out_a", bus.out_a, m_a);
                chk("out_b", bus.out_b, m_b);
            end
        end
    end

    task automatic step();
        model_update();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic v, input logic [3:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic ui);
        bus.in_valid = v; bus.in_op = op; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_rd = rd; bus.in_imm = imm; bus.in_use_imm = ui;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst rf_a1", {27'd0, bus.rf_a1}, 32'd0);
        chk("rst rf_a2", {27'd0, bus.rf_a2}, 32'd0);
        chk("rst stall", {28'd0, bus.stall_count}, 32'd0);
        chk("rst out_a", bus.out_a, 32'd0);
        chk("rst out_b", bus.out_b, 32'd0);
        chk("rst out_op_rd", {23'd0, bus.out_op, bus.out_rd}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin regval[r] = 32'd0; regv[r] = 1'b0; end
        regv[0] = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        bus.wb_en = 1'b0; bus.wb_a = 5'd0; bus.wb_data = 32'd0;
        model_reset();
        #2;
        do_reset();

        // Both operands ready: packet after the second edge
        regval[3] = 32'd10; regv[3] = 1'b1;
        regval[4] = 32'd20; regv[4] = 1'b1;
        put(1, 4'h2, 5'd3, 5'd4, 5'd9, 32'd0, 0);
        step();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("t1 not yet valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("t1 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1 out_a", bus.out_a, 32'd10);
        chk("t1 out_b", bus.out_b, 32'd20);
        chk("t1 stall", {28'd0, bus.stall_count}, 32'd0);
        step();

        // rs1 late by three cycles, rs2 = x0
        put(1, 4'h3, 5'd5, 5'd0, 5'd10, 32'd0, 0);
        step();
        put(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("t2 waiting", {31'd0, bus.out_valid}, 32'd0);
        regval[5] = 32'd55; regv[5] = 1'b1;
        step();
        chk("t2 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t2 out_a", bus.out_a, 32'd55);
        chk("t2 out_b", bus.out_b, 32'd0);
        chk("t2 stall", {28'd0, bus.stall_count}, 32'd3);
        step();

        // Immediate operand B with rs2 never ready
        put(1, 4'h5, 5'd3, 5'd9, 5'd11, 32'hFFFF_FFF0, 1);
        step();
        put(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t3 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t3 out_b", bus.out_b, 32'hFFFF_FFF0);

        // Back-pressure in FULL, then consume and accept on the same edge
        bus.out_ready = 1'b0;
        put(1, 4'h6, 5'd3, 5'd4, 5'd12, 32'd0, 0);
        repeat (4) begin
            step();
            chk("t4 in_ready held", {31'd0, bus.in_ready}, 32'd0);
            chk("t4 out_b held", bus.out_b, 32'hFFFF_FFF0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4 in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("t4 reloaded", {31'd0, bus.out_valid}, 32'd0);
        chk("t4 rf_a1", {27'd0, bus.rf_a1}, 32'd3);
        put(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t4 next out_a", bus.out_a, 32'd10);
        step();

        // Writeback snoop on a register the rf reports as not ready
        regv[7] = 1'b0;
        bus.wb_en = 1'b1; bus.wb_a = 5'd7; bus.wb_data = 32'h1234;
        put(1, 4'h7, 5'd7, 5'd0, 5'd13, 32'd0, 0);
        step();
        put(0, 0, 0, 0, 0, 0, 0);
        step();
`ifdef OPFETCH_BYPASS_EN
        chk("t5 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t5 out_a", bus.out_a, 32'h1234);
`else
        chk("t5 still waiting", {31'd0, bus.out_valid}, 32'd0);
        chk("t5 rf_a1", {27'd0, bus.rf_a1}, 32'd7);
`endif
        bus.wb_en = 1'b0;
        regval[7] = 32'd77; regv[7] = 1'b1;
        repeat (3) step();

        // Saturation, then reset while waiting
        regv[5] = 1'b0;
        put(1, 4'h1, 5'd5, 5'd0, 5'd1, 32'd0, 0);
        step();
        put(0, 0, 0, 0, 0, 0, 0);
        repeat (20) step();
        chk("t6 stall sat", {28'd0, bus.stall_count}, SAT);
        do_reset();

        // Reset while holding a full packet
        bus.out_ready = 1'b0;
        put(1, 4'h2, 5'd3, 5'd4, 5'd9, 32'd0, 0);
        step();
        put(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t7 full", {31'd0, bus.out_valid}, 32'd1);
        do_reset();
        bus.out_ready = 1'b1;
        put(1, 4'h4, 5'd4, 5'd3, 5'd2, 32'd0, 0);
        step();
        put(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t7 reissue out_a", bus.out_a, 32'd20);
        chk("t7 reissue out_b", bus.out_b, 32'd10);
        step();

        // Randomized traffic against the reference
        for (int c = 0; c < 1500; c++) begin
            put(1'($urandom % 2), 4'($urandom), 5'($urandom % 8), 5'($urandom % 8),
                5'($urandom), $urandom, 1'(($urandom % 4) == 0));
            bus.out_ready = 1'(($urandom % 4) != 0);
            for (int r = 1; r < 8; r++) begin
                regv[r]   = 1'(($urandom % 3) == 0);
                regval[r] = $urandom;
            end
            bus.wb_en   = 1'(($urandom % 3) == 0);
            bus.wb_a    = 5'($urandom % 8);
            bus.wb_data = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
